// File: rtl/vliw_regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : vliw_regfile_sb_if
//  Description : Bundle of the issue-stage and writeback signals of the
//                multi-lane register file with scoreboard.
//                master : issue/writeback side (drives addresses, writes, issues)
//                slave  : register file (returns operands, busy, conflict info)
//  Signals     : rs1_addr/rs2_addr   per-lane source addresses
//                rs1_data/rs2_data   per-lane operand data (combinational)
//                rs1_busy/rs2_busy   per-lane operand pending-write flags
//                wr_en/wr_addr/wr_data  per-lane writeback
//                iss_en/iss_rd       per-lane issue (marks destination pending)
//                wr_conflict/wr_conflict_addr  registered conflict report
//                busy_count          registered count of pending registers
//  Revision    : 1.0  initial release
// ============================================================================
interface vliw_regfile_sb_if #(
  parameter int NUM_LANES = 3,
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CNT_W  = $clog2(NUM_REGS + 1);

  logic [NUM_LANES*ADDR_W-1:0] rs1_addr;
  logic [NUM_LANES*ADDR_W-1:0] rs2_addr;
  logic [NUM_LANES*DATA_W-1:0] rs1_data;
  logic [NUM_LANES*DATA_W-1:0] rs2_data;
  logic [NUM_LANES-1:0]        rs1_busy;
  logic [NUM_LANES-1:0]        rs2_busy;
  logic [NUM_LANES-1:0]        wr_en;
  logic [NUM_LANES*ADDR_W-1:0] wr_addr;
  logic [NUM_LANES*DATA_W-1:0] wr_data;
  logic [NUM_LANES-1:0]        iss_en;
  logic [NUM_LANES*ADDR_W-1:0] iss_rd;
  logic                        wr_conflict;
  logic [ADDR_W-1:0]           wr_conflict_addr;
  logic [CNT_W-1:0]            busy_count;

  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy,
           wr_conflict, wr_conflict_addr, busy_count
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, iss_en, iss_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy,
           wr_conflict, wr_conflict_addr, busy_count
  );
endinterface
`default_nettype wire

// File: rtl/vliw_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : vliw_regfile_sb
//  Description : Multi-lane VLIW register file with write-first read bypass,
//                highest-lane-wins write arbitration with conflict reporting,
//                optional hardwired zero register and a per-register
//                scoreboard of pending writebacks.
//  Ports       : clk  - clock, all state on rising edge
//                rst  - asynchronous active-high reset
//                bus  - vliw_regfile_sb_if.slave (operand reads, busy flags,
//                       writebacks, issues, conflict report, busy count)
//  Revision    : 1.0  initial release
// ============================================================================
module vliw_regfile_sb #(
  parameter int NUM_LANES = 3,
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int ZERO_REG  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  vliw_regfile_sb_if.slave      bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CNT_W  = $clog2(NUM_REGS + 1);
  localparam bit c_zero = (ZERO_REG != 0);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_conflict;
  logic [ADDR_W-1:0]   r_conflict_addr;
  logic [CNT_W-1:0]    r_busy_count;

  // --------------------------------------------------------------------------
  // Per-register write/issue decode.
  // Lanes are scanned in ascending order so the last match (highest lane)
  // leaves its data in w_wr_val. w_multi marks a register hit a second time.
  // Register 0 is excluded entirely when it is hardwired to zero, so it never
  // takes data, never raises a conflict and never becomes busy.
  // --------------------------------------------------------------------------
  logic [NUM_REGS-1:0] w_wr_hit;
  logic [NUM_REGS-1:0] w_multi;
  logic [NUM_REGS-1:0] w_iss_hit;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [DATA_W-1:0]   w_wr_val [NUM_REGS];
  logic                w_conf_any;
  logic [ADDR_W-1:0]   w_conf_addr;
  logic [CNT_W-1:0]    w_cnt;

  always_comb begin
    w_wr_hit  = '0;
    w_multi   = '0;
    w_iss_hit = '0;
    for (int j = 0; j < NUM_REGS; j++) begin
      w_wr_val[j] = '0;
    end

    for (int j = 0; j < NUM_REGS; j++) begin
      if (!(c_zero && j == 0)) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (bus.wr_en[l] && bus.wr_addr[l*ADDR_W +: ADDR_W] == ADDR_W'(j)) begin
            w_multi[j]  = w_multi[j] | w_wr_hit[j];
            w_wr_hit[j] = 1'b1;
            w_wr_val[j] = bus.wr_data[l*DATA_W +: DATA_W];
          end
          if (bus.iss_en[l] && bus.iss_rd[l*ADDR_W +: ADDR_W] == ADDR_W'(j)) begin
            w_iss_hit[j] = 1'b1;
          end
        end
      end
    end

    // Issue wins over a same-cycle writeback: the writeback retires the old
    // producer while the issue registers a new one.
    w_busy_nxt = (r_busy & ~w_wr_hit) | w_iss_hit;

    // Descending scan leaves the lowest conflicting address.
    w_conf_any  = |w_multi;
    w_conf_addr = '0;
    for (int j = NUM_REGS - 1; j >= 0; j--) begin
      if (w_multi[j]) begin
        w_conf_addr = ADDR_W'(j);
      end
    end

    w_cnt = '0;
    for (int j = 0; j < NUM_REGS; j++) begin
      w_cnt = w_cnt + CNT_W'(w_busy_nxt[j]);
    end
  end

  // --------------------------------------------------------------------------
  // Storage, scoreboard and registered status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NUM_REGS; j++) begin
        r_regs[j] <= '0;
      end
      r_busy          <= '0;
      r_conflict      <= 1'b0;
      r_conflict_addr <= '0;
      r_busy_count    <= '0;
    end else begin
      for (int j = 0; j < NUM_REGS; j++) begin
        if (w_wr_hit[j]) begin
          r_regs[j] <= w_wr_val[j];
        end
      end
      r_busy       <= w_busy_nxt;
      r_conflict   <= w_conf_any;
      if (w_conf_any) begin
        r_conflict_addr <= w_conf_addr;
      end
      r_busy_count <= w_cnt;
    end
  end

  assign bus.wr_conflict      = r_conflict;
  assign bus.wr_conflict_addr = r_conflict_addr;
  assign bus.busy_count       = r_busy_count;

  // --------------------------------------------------------------------------
  // Read ports: write-first bypass of the winning writeback, and a busy flag
  // that already sees this cycle's clearing writeback (but not new issues).
  // --------------------------------------------------------------------------
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [ADDR_W-1:0] w_a1;
    logic [ADDR_W-1:0] w_a2;
    logic [DATA_W-1:0] w_d1;
    logic [DATA_W-1:0] w_d2;

    assign w_a1 = bus.rs1_addr[l*ADDR_W +: ADDR_W];
    assign w_a2 = bus.rs2_addr[l*ADDR_W +: ADDR_W];

    assign w_d1 = (c_zero && w_a1 == '0) ? '0 :
                  (w_wr_hit[w_a1] ? w_wr_val[w_a1] : r_regs[w_a1]);
    assign w_d2 = (c_zero && w_a2 == '0) ? '0 :
                  (w_wr_hit[w_a2] ? w_wr_val[w_a2] : r_regs[w_a2]);

    assign bus.rs1_data[l*DATA_W +: DATA_W] = w_d1;
    assign bus.rs2_data[l*DATA_W +: DATA_W] = w_d2;
    assign bus.rs1_busy[l] = r_busy[w_a1] & ~w_wr_hit[w_a1];
    assign bus.rs2_busy[l] = r_busy[w_a2] & ~w_wr_hit[w_a2];
  end

endmodule
`default_nettype wire

// File: doc/vliw_regfile_sb.md
Name: vliw_regfile_sb

Overview:
Parametrised multi-lane register file for the VLIW core, with one read-pair/write port set per issue lane. It adds write-first read bypass, deterministic multi-lane write arbitration with conflict reporting, an optional hardwired zero register, and a per-register scoreboard that tracks pending writebacks. It sits between the issue stage (operand reads, scoreboard checks) and the LSU/IXU writeback buses.

Parameters:
NUM_LANES, 3, number of issue lanes (lane 0 = LSU, 1 = IXU1, 2 = IXU2 by default)
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of two, >= 2)
ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy
(derived localparam ADDR_W = $clog2(NUM_REGS); CNT_W = $clog2(NUM_REGS+1))

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
rs1_addr  in  NUM_LANES*ADDR_W  per-lane source-1 address, lane i at [i*ADDR_W +: ADDR_W]
rs2_addr  in  NUM_LANES*ADDR_W  per-lane source-2 address
rs1_data  out  NUM_LANES*DATA_W  per-lane source-1 data, combinational
rs2_data  out  NUM_LANES*DATA_W  per-lane source-2 data, combinational
rs1_busy  out  NUM_LANES  source-1 register has a pending write
rs2_busy  out  NUM_LANES  source-2 register has a pending write
wr_en  in  NUM_LANES  per-lane writeback enable
wr_addr  in  NUM_LANES*ADDR_W  per-lane writeback destination
wr_data  in  NUM_LANES*DATA_W  per-lane writeback data
iss_en  in  NUM_LANES  per-lane issue: mark destination pending
iss_rd  in  NUM_LANES*ADDR_W  per-lane issued destination
wr_conflict  out  1  registered pulse: >=2 lanes wrote same register last cycle
wr_conflict_addr  out  ADDR_W  register of the last conflict (lowest address if several)
busy_count  out  CNT_W  registered number of busy registers

Behaviour:
- Reset (async assert, sync release): all registers = 0, all busy bits = 0, wr_conflict = 0, wr_conflict_addr = 0, busy_count = 0. Reset mid-operation discards in-flight writes/issues.
- Write: on clock edge, reg[wr_addr[i]] <= wr_data[i] for each lane with wr_en[i]=1. Same address from several lanes: highest lane index wins; others dropped.
- Conflict: wr_conflict = 1 in the cycle after any address is written by >=2 lanes, else 0; wr_conflict_addr updates only when flagged, holds otherwise. Writes to reg 0 with ZERO_REG=1 never count.
- Read: combinational, write-first bypass. If any lane writes the read address this cycle, rs*_data = winning (highest-lane) wr_data; else stored value. ZERO_REG=1 and address 0 -> 0, regardless of writes.
- Scoreboard: iss_en[i] sets busy[iss_rd[i]] at edge; wr_en[i] clears busy[wr_addr[i]] at edge. Set and clear of same register in one cycle -> set wins (new producer issued after old writeback). Issue to reg 0 ignored when ZERO_REG=1.
- rs*_busy = busy[addr] AND NOT (any wr_en to addr this cycle) (clear bypass); issue this cycle is not forwarded to busy outputs.
- busy_count = popcount of busy bits after update, registered (reflects state same edge busy bits change).
- No reset value on combinational outputs beyond what storage reset implies (all reads 0, busy 0 during reset).

Test Plan:
- Reset then read all 32 addrs on every lane -> rs1/rs2_data = 0, busy = 0, busy_count = 0.
- Lane 1 writes r5 = 0xDEADBEEF; same cycle lane 0 reads r5 -> rs1_data = 0xDEADBEEF (bypass); next cycle lane 2 reads r5 -> 0xDEADBEEF.
- Lanes 0,1,2 all write r7 = 0x11/0x22/0x33 same cycle -> r7 = 0x33, wr_conflict = 1 for exactly one cycle with wr_conflict_addr = 7; lanes 0,1 write r0 -> no conflict, r0 reads 0.
- Lane 0 issues r3, lane 2 issues r9 -> next cycle busy for r3/r9 = 1, busy_count = 2; lane 1 writes r3 -> rs1_busy for r3 = 0 that cycle, busy_count = 1 after edge.
- Same cycle: lane 1 writes r4 (busy) and lane 2 issues r4 -> r4 stays busy, busy_count unchanged.
- Assert rst asynchronously mid-cycle with r5 = 0xDEADBEEF, r3 busy -> immediately reads 0, busy 0, busy_count 0, wr_conflict 0.
